// File: rtl/intdiv_sd2_to_bin.sv
// intdiv_sd2_to_bin
// Serial SD2 -> two's-complement converter for the quotient side of the SD2
// integer divider. Digits arrive MSB-first in (p,n) encoding and are folded
// into Q / QM by on-the-fly conversion (QM == Q-1 always), so no
// carry-propagate adder is needed. After N digits the N-bit quotient and an
// overflow flag are presented through a valid/ready handshake.
//
// Optional feature: define INTDIV_SD2BIN_CORR_EN to add the in_corr port.
// in_corr is sampled with the Nth digit; when set, the word presented is
// the quotient minus one, taken from QM.
module intdiv_sd2_to_bin #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_digit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_q,
  output logic         out_ovf
`ifdef INTDIV_SD2BIN_CORR_EN
  ,
  input  logic         in_corr
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N:0]    q;
  logic [N:0]    qm;

  logic [N:0]    q_nxt;
  logic [N:0]    qm_nxt;
  logic [N:0]    res;
  logic          dig_fire;
  logic          last_dig;

  assign dig_fire = in_valid & in_ready;
  assign last_dig = (cnt == CW'(N - 1));

  // On-the-fly conversion step for the incoming digit; both zero codes append 0
  always_comb begin
    q_nxt  = q;
    qm_nxt = qm;
    case (in_digit)
      2'b10: begin
        q_nxt  = (q << 1) | {{N{1'b0}}, 1'b1};
        qm_nxt = q << 1;
      end
      2'b01: begin
        q_nxt  = (qm << 1) | {{N{1'b0}}, 1'b1};
        qm_nxt = qm << 1;
      end
      default: begin
        q_nxt  = q << 1;
        qm_nxt = (qm << 1) | {{N{1'b0}}, 1'b1};
      end
    endcase
  end

  // Final word selection: QM path yields quotient-1 when a correction is requested
  always_comb begin
`ifdef INTDIV_SD2BIN_CORR_EN
    res = in_corr ? qm_nxt : q_nxt;
`else
    res = q_nxt;
`endif
  end

  // Control FSM, conversion registers and registered handshake/result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      cnt       <= '0;
      q         <= '0;
      qm        <= '1;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_ovf   <= 1'b0;
    end else if (flush) begin
      state     <= ACCUM;
      cnt       <= '0;
      q         <= '0;
      qm        <= '1;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (dig_fire) begin
            q   <= q_nxt;
            qm  <= qm_nxt;
            cnt <= cnt + 1'b1;
            if (last_dig) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_q     <= res[N-1:0];
              out_ovf   <= res[N] ^ res[N-1];
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= ACCUM;
            cnt       <= '0;
            q         <= '0;
            qm        <= '1;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          cnt       <= '0;
          q         <= '0;
          qm        <= '1;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intdiv_sd2_to_bin.sv
// Directed bench for intdiv_sd2_to_bin with N=4.
module tb_intdiv_sd2_to_bin;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_digit;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_q;
  logic         out_ovf;
`ifdef INTDIV_SD2BIN_CORR_EN
  logic         in_corr;
`endif

  int vectors     = 0;
  int miscompares = 0;

  intdiv_sd2_to_bin #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_ovf   (out_ovf)
`ifdef INTDIV_SD2BIN_CORR_EN
    ,
    .in_corr   (in_corr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Four digits back-to-back (d[7:6] first), then check the presented word.
  task automatic feed(input string tag, input logic [7:0] d, input logic corr,
                      input logic [N-1:0] exp_q, input logic exp_ovf);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_digit = d[7-2*i -: 2];
`ifdef INTDIV_SD2BIN_CORR_EN
      in_corr  = (i == 3) ? corr : 1'b0;
`else
      if (corr) $display("note: correction ignored in this build");
`endif
      @(negedge clk);
      if (i < 3) chk({tag, "_busy_valid"}, 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    in_digit = 2'b00;
`ifdef INTDIV_SD2BIN_CORR_EN
    in_corr  = 1'b0;
`endif
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_q"},     32'(out_q), 32'(exp_q));
    chk({tag, "_ovf"},   32'(out_ovf), 32'(exp_ovf));
  endtask

  task automatic drain(input string tag, input logic [N-1:0] exp_q);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_drain_hold"},  32'(out_q), 32'(exp_q));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_digit = 2'b00; out_ready = 1'b0;
`ifdef INTDIV_SD2BIN_CORR_EN
    in_corr = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_q",     32'(out_q), 32'd0);
    chk("rst_ovf",   32'(out_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // 8 + 0 - 2 + 1 = 7
    feed("w7", 8'b10_00_01_10, 1'b0, 4'b0111, 1'b0);
    drain("w7", 4'b0111);
    // -8 with the 11 zero code
    feed("wm8", 8'b01_11_00_00, 1'b0, 4'b1000, 1'b0);
    drain("wm8", 4'b1000);
    // 15 overflows
    feed("w15", 8'b10_10_10_10, 1'b0, 4'b1111, 1'b1);
    drain("w15", 4'b1111);

    // 0 + 4 - 2 - 1 = 1, consumer stalls three cycles with a digit pending
    feed("w1", 8'b00_10_01_01, 1'b0, 4'b0001, 1'b0);
    in_valid = 1'b1;
    in_digit = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_q",     32'(out_q), 32'd1);
    end
    in_valid = 1'b0;
    drain("w1", 4'b0001);
    // next word starts the cycle after the transfer
    feed("w1b", 8'b10_01_01_01, 1'b0, 4'b0001, 1'b0);
    drain("w1b", 4'b0001);

    // flush mid-word: two digits, then flush with a simultaneous digit
    in_valid = 1'b1;
    in_digit = 2'b10;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    feed("wflush", 8'b00_00_00_10, 1'b0, 4'b0001, 1'b0);
    drain("wflush", 4'b0001);

    // flush in DONE wins over out_ready; value 8 overflows
    feed("w8", 8'b10_00_00_00, 1'b0, 4'b1000, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    chk("flush_done_valid", 32'(out_valid), 32'd0);
    chk("flush_done_ready", 32'(in_ready), 32'd1);
    chk("flush_done_hold",  32'(out_q), 32'b1000);

    // async reset while a word is presented (-15 overflows)
    feed("wm15", 8'b01_01_01_01, 1'b0, 4'b0001, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_q",     32'(out_q), 32'd0);
    chk("arst_ovf",   32'(out_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_release_ready", 32'(in_ready), 32'd1);
    feed("w2", 8'b00_00_10_00, 1'b0, 4'b0010, 1'b0);
    drain("w2", 4'b0010);

`ifdef INTDIV_SD2BIN_CORR_EN
    feed("corr1", 8'b00_00_10_00, 1'b1, 4'b0001, 1'b0);
    drain("corr1", 4'b0001);
    feed("corr0", 8'b00_00_10_00, 1'b0, 4'b0010, 1'b0);
    drain("corr0", 4'b0010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
